vending_fsm: RTL and testbench
==============================

Name: vending_fsm

Overview:
- Coin-operated drink dispenser controller. The product price is 3 credit units.
- Accepts three coin inputs: B1 = 1 unit, B2 = 2 units, B3 = 5 units.
- On reaching or exceeding the price, pulses EB (dispense drink) and returns change as pulses on EB1 (1-unit coin) and EB2 (2-unit coin).
- Sits between the coin acceptor (level inputs) and the dispense/change actuators (one-cycle pulses).

Parameters:
- None. Price (3) and denominations (1/2/5) are fixed.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high; clears all state and outputs
- B1  input  1  1-unit coin present (level; one coin per 0->1 transition)
- B2  input  1  2-unit coin present (level; one coin per 0->1 transition)
- B3  input  1  5-unit coin present (level; one coin per 0->1 transition)
- EB  output  1  dispense drink, one-cycle registered pulse
- EB1  output  1  return one 1-unit coin, one-cycle registered pulse
- EB2  output  1  return one 2-unit coin, one-cycle registered pulse
- credit  output  2  current accumulated credit (only with FSM_CREDIT_OUT_EN)

Behaviour:
- Interface: one clock domain (clk). reset is asynchronous and active-high.
- Reset values:
  - State = IDLE.
  - EB = EB1 = EB2 = 0.
  - Coin edge-detect history registers = 0, so a coin input already high when reset releases counts as one coin on the first clock.
- Coin detection: rise_x = Bx & ~Bx_prev, registered each clock. A level held for any number of cycles is one coin.
- Simultaneous rises: only the highest value is credited (B3 > B2 > B1); the others are discarded, not queued.
- States:
  - IDLE: credit 0.
  - C1: credit 1.
  - C2: credit 2.
  - VEND: EB high.
  - CHG2: second 2-unit change pulse.
- Transitions: total = credit + coin value.
  - total < 3: go to the matching credit state.
  - total >= 3: go to VEND; change = total - 3.
- Outputs are registered and asserted in the cycle following the sampling edge, i.e. 1-cycle latency from the edge that sees the rise.
- Change encoding in the VEND cycle:
  - 0: none.
  - 1: EB1.
  - 2: EB2.
  - 3: EB1 + EB2.
  - 4 (only C2 + B3): EB2, then CHG2 issues a second EB2 pulse next cycle.
- Exit: VEND -> IDLE, or VEND -> CHG2 when change is 4; CHG2 -> IDLE. All outputs drop to 0 in IDLE/C1/C2.
- Coins rising during VEND or CHG2 are ignored and lost. Their edge history still updates, so the held coin is not recounted later.
- Reset mid-operation: credit is lost, outputs drop immediately, and no change is returned.
- No coin activity: state holds indefinitely, no timeout.

Optional Feature:
- Macro FSM_CREDIT_OUT_EN.
- Defined: adds output credit[1:0], combinationally decoded from state: IDLE = 0, C1 = 1, C2 = 2, VEND/CHG2 = 0.
- Undefined: port absent; all other behaviour identical.

Test Plan:
- reset high 20 ns, release with B1 = B2 = 0 and B3 = 1 held 40 ns -> EB = 1 and EB2 = 1 for exactly one cycle at the first posedge after release, then IDLE; no second vend while B3 stays high.
- Pulse B1 three times (separate 0->1 edges) -> credit 1, 2, then EB only; EB1 = EB2 = 0.
- Pulse B1 then B2 -> EB alone. Pulse B2 then B2 -> EB + EB1 in the same cycle.
- Pulse B2, B2 held low, then B3 -> EB + EB2 in cycle n, EB2 again in cycle n+1, EB = 0 in n+1, then IDLE.
- B1 and B3 rise on the same cycle -> only 5 credited: EB + EB2, no extra change.
- Pulse B2 then assert reset asynchronously mid-cycle -> outputs 0 immediately. A following single B1 gives no vend (credit restarted at 1).

Source files
------------

// File: rtl/vending_fsm_if.sv
// Coin acceptor / actuator bundle for vending_fsm.
// The credit signal exists only when FSM_CREDIT_OUT_EN is defined.
interface vending_fsm_if;
    logic       B1;
    logic       B2;
    logic       B3;
    logic       EB;
    logic       EB1;
    logic       EB2;
`ifdef FSM_CREDIT_OUT_EN
    logic [1:0] credit;
`endif

    modport master (
        output B1, B2, B3,
`ifdef FSM_CREDIT_OUT_EN
        input  credit,
`endif
        input  EB, EB1, EB2
    );

    modport slave (
        input  B1, B2, B3,
`ifdef FSM_CREDIT_OUT_EN
        output credit,
`endif
        output EB, EB1, EB2
    );
endinterface

// File: rtl/vending_fsm.sv
// Drink dispenser controller: price 3, coins 1/2/5, change paid as 1- and 2-unit pulses.
// Optional FSM_CREDIT_OUT_EN exposes the accumulated credit decoded from state.
//
// state | meaning
// IDLE  | credit 0
// C1    | credit 1
// C2    | credit 2
// VEND  | EB pulse plus first change pulse(s)
// CHG2  | second 2-unit change pulse (change of 4)
module vending_fsm (
    input  logic          clk,
    input  logic          reset,
    vending_fsm_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        C1   = 3'd1,
        C2   = 3'd2,
        VEND = 3'd3,
        CHG2 = 3'd4
    } state_t;

    state_t      r_state;
    logic [2:0]  r_b_prev;
    logic        r_eb;
    logic        r_eb1;
    logic        r_eb2;
    logic        r_chg4;

    logic [2:0]  w_rise;
    logic [2:0]  w_coin_val;
    logic [1:0]  w_credit;
    logic [2:0]  w_total;
    logic [2:0]  w_change;

    assign w_rise = {bus.B3, bus.B2, bus.B1} & ~r_b_prev;

    // Highest denomination wins when several coins rise together.
    always_comb begin
        w_coin_val = 3'd0;
        if (w_rise[2])
            w_coin_val = 3'd5;
        else if (w_rise[1])
            w_coin_val = 3'd2;
        else if (w_rise[0])
            w_coin_val = 3'd1;
    end

    always_comb begin
        w_credit = 2'd0;
        case (r_state)
            C1:      w_credit = 2'd1;
            C2:      w_credit = 2'd2;
            default: w_credit = 2'd0;
        endcase
    end

    assign w_total  = {1'b0, w_credit} + w_coin_val;
    assign w_change = w_total - 3'd3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_b_prev <= 3'b000;
            r_eb     <= 1'b0;
            r_eb1    <= 1'b0;
            r_eb2    <= 1'b0;
            r_chg4   <= 1'b0;
        end else begin
            r_b_prev <= {bus.B3, bus.B2, bus.B1};
            r_eb     <= 1'b0;
            r_eb1    <= 1'b0;
            r_eb2    <= 1'b0;
            case (r_state)
                IDLE, C1, C2: begin
                    r_chg4 <= 1'b0;
                    if (w_coin_val != 3'd0) begin
                        if (w_total < 3'd3) begin
                            r_state <= (w_total == 3'd1) ? C1 : C2;
                        end else begin
                            r_state <= VEND;
                            r_eb    <= 1'b1;
                            r_eb1   <= w_change[0];
                            r_eb2   <= (w_change >= 3'd2);
                            r_chg4  <= (w_change == 3'd4);
                        end
                    end
                end
                VEND: begin
                    // Coins rising here are dropped; only their history updates.
                    if (r_chg4) begin
                        r_state <= CHG2;
                        r_eb2   <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                    r_chg4 <= 1'b0;
                end
                CHG2: begin
                    r_state <= IDLE;
                    r_chg4  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_chg4  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.EB  = r_eb;
    assign bus.EB1 = r_eb1;
    assign bus.EB2 = r_eb2;

`ifdef FSM_CREDIT_OUT_EN
    assign bus.credit = w_credit;
`endif

endmodule

// File: tb/tb_vending_fsm.sv
// Scoreboard bench for vending_fsm: expected {EB,EB1,EB2} (and credit when enabled)
// queued as each cycle of stimulus is driven, popped and compared after the edge.
module tb_vending_fsm;

    logic clk;
    logic reset;

    vending_fsm_if bus_if ();

    vending_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] outs;
        logic [1:0] cr;
        string      tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of coin levels from a negedge, queue the expectation,
    // then compare after the next posedge and return at the following negedge.
    task automatic cyc(input logic b1, input logic b2, input logic b3,
                       input logic [2:0] exp_outs, input logic [1:0] exp_cr,
                       input string tag);
        exp_t e;
        exp_t got;
        bus_if.B1 = b1;
        bus_if.B2 = b2;
        bus_if.B3 = b3;
        e.outs = exp_outs;
        e.cr   = exp_cr;
        e.tag  = tag;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        chk(got.tag, {5'd0, bus_if.EB, bus_if.EB1, bus_if.EB2}, {5'd0, got.outs});
`ifdef FSM_CREDIT_OUT_EN
        chk({got.tag, "_credit"}, {6'd0, bus_if.credit}, {6'd0, got.cr});
`endif
        @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        bus_if.B1 = 1'b0;
        bus_if.B2 = 1'b0;
        bus_if.B3 = 1'b1;
        #12;
        chk("reset_outs", {5'd0, bus_if.EB, bus_if.EB1, bus_if.EB2}, 8'd0);
        @(negedge clk);
        reset = 1'b0;

        // B3 already high at release counts once: vend + 2 change.
        cyc(0, 0, 1, 3'b101, 2'd0, "rel_b3_vend");
        cyc(0, 0, 1, 3'b000, 2'd0, "rel_b3_idle");
        cyc(0, 0, 1, 3'b000, 2'd0, "rel_b3_hold1");
        cyc(0, 0, 1, 3'b000, 2'd0, "rel_b3_hold2");
        cyc(0, 0, 0, 3'b000, 2'd0, "rel_b3_drop");

        cyc(1, 0, 0, 3'b000, 2'd1, "b1x3_c1");
        cyc(0, 0, 0, 3'b000, 2'd1, "b1x3_c1_low");
        cyc(1, 0, 0, 3'b000, 2'd2, "b1x3_c2");
        cyc(0, 0, 0, 3'b000, 2'd2, "b1x3_c2_low");
        cyc(1, 0, 0, 3'b100, 2'd0, "b1x3_vend");
        cyc(0, 0, 0, 3'b000, 2'd0, "b1x3_idle");

        cyc(1, 0, 0, 3'b000, 2'd1, "b1b2_c1");
        cyc(0, 0, 0, 3'b000, 2'd1, "b1b2_low");
        cyc(0, 1, 0, 3'b100, 2'd0, "b1b2_vend");
        cyc(0, 0, 0, 3'b000, 2'd0, "b1b2_idle");

        cyc(0, 1, 0, 3'b000, 2'd2, "b2b2_c2");
        cyc(0, 0, 0, 3'b000, 2'd2, "b2b2_low");
        cyc(0, 1, 0, 3'b110, 2'd0, "b2b2_vend");
        cyc(0, 0, 0, 3'b000, 2'd0, "b2b2_idle");

        cyc(0, 1, 0, 3'b000, 2'd2, "b2b3_c2");
        cyc(0, 0, 0, 3'b000, 2'd2, "b2b3_low");
        cyc(0, 0, 1, 3'b101, 2'd0, "b2b3_vend");
        cyc(0, 0, 1, 3'b001, 2'd0, "b2b3_chg2");
        cyc(0, 0, 0, 3'b000, 2'd0, "b2b3_idle");

        cyc(1, 0, 1, 3'b101, 2'd0, "b1b3_same_vend");
        cyc(0, 0, 0, 3'b000, 2'd0, "b1b3_same_idle");

        cyc(1, 0, 0, 3'b000, 2'd1, "b1b3_c1");
        cyc(0, 0, 0, 3'b000, 2'd1, "b1b3_low");
        cyc(0, 0, 1, 3'b111, 2'd0, "b1b3_vend");
        cyc(0, 0, 0, 3'b000, 2'd0, "b1b3_idle");

        // A coin rising during VEND is lost and not recounted while held.
        cyc(0, 1, 0, 3'b000, 2'd2, "lost_c2");
        cyc(0, 0, 0, 3'b000, 2'd2, "lost_low");
        cyc(0, 1, 0, 3'b110, 2'd0, "lost_vend");
        cyc(1, 1, 0, 3'b000, 2'd0, "lost_b1_in_vend");
        cyc(1, 0, 0, 3'b000, 2'd0, "lost_b1_held");
        cyc(0, 0, 0, 3'b000, 2'd0, "lost_b1_drop");
        cyc(0, 1, 0, 3'b000, 2'd2, "lost_after_c2");
        cyc(0, 0, 0, 3'b000, 2'd2, "lost_after_low");
        cyc(1, 0, 0, 3'b100, 2'd0, "lost_after_vend");
        cyc(0, 0, 0, 3'b000, 2'd0, "lost_after_idle");

        cyc(1, 0, 0, 3'b000, 2'd1, "hold_c1");
        for (int i = 0; i < 5; i++)
            cyc(0, 0, 0, 3'b000, 2'd1, "hold_wait");
        cyc(0, 1, 0, 3'b100, 2'd0, "hold_vend");
        cyc(0, 0, 0, 3'b000, 2'd0, "hold_idle");

        // Async reset with credit 2, then a single B1 must not vend.
        cyc(0, 1, 0, 3'b000, 2'd2, "rst_c2");
        cyc(0, 0, 0, 3'b000, 2'd2, "rst_c2_low");
        #2 reset = 1'b1;
        #1 chk("rst_mid_outs", {5'd0, bus_if.EB, bus_if.EB1, bus_if.EB2}, 8'd0);
        #1 reset = 1'b0;
        @(negedge clk);
        cyc(1, 0, 0, 3'b000, 2'd1, "rst_b1_c1");
        cyc(0, 0, 0, 3'b000, 2'd1, "rst_b1_low1");
        cyc(0, 0, 0, 3'b000, 2'd1, "rst_b1_low2");

        // Async reset during VEND drops EB at once.
        cyc(0, 1, 0, 3'b100, 2'd0, "rst_vend");
        reset = 1'b1;
        #1 chk("rst_vend_outs", {5'd0, bus_if.EB, bus_if.EB1, bus_if.EB2}, 8'd0);
        #1 reset = 1'b0;
        bus_if.B2 = 1'b0;
        @(negedge clk);

        // Async reset in VEND with change 4 suppresses the CHG2 pulse.
        cyc(0, 1, 0, 3'b000, 2'd2, "rst_chg_c2");
        cyc(0, 0, 0, 3'b000, 2'd2, "rst_chg_low");
        cyc(0, 0, 1, 3'b101, 2'd0, "rst_chg_vend");
        bus_if.B3 = 1'b0;
        reset = 1'b1;
        #1 chk("rst_chg_outs", {5'd0, bus_if.EB, bus_if.EB1, bus_if.EB2}, 8'd0);
        #1 reset = 1'b0;
        @(negedge clk);
        cyc(0, 0, 0, 3'b000, 2'd0, "rst_chg_no_chg2");
        cyc(0, 0, 0, 3'b000, 2'd0, "rst_chg_idle");

        chk("sb_drained", 8'(sb_q.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
